// File: rtl/veririsc_pkg.sv
// veririsc_pkg: opcode and FSM state encodings shared by the VeriRISC core and ALU.
package veririsc_pkg;
  localparam int OPW = 3;
  typedef enum logic [OPW-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_OPRD   = 3'd2,
    S_OPWR   = 3'd3,
    S_HALTED = 3'd4
  } state_e;
endpackage

// File: rtl/veririsc_alu.sv
// veririsc_alu: combinational accumulator ALU; ADD drops the carry, LDA passes the operand.
module veririsc_alu
  import veririsc_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  opcode_e           op,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic [DWIDTH-1:0] y
);
  always_comb
    y = op == OP_ADD ? a + b :
        op == OP_AND ? a & b :
        op == OP_XOR ? a ^ b : b;
endmodule

// File: rtl/veririsc_core.sv
// veririsc_core: multicycle accumulator CPU with stallable memory port.
// Define VERIRISC_RESUME_EN to add a resume input that restarts fetch from HALTED.
module veririsc_core
  import veririsc_pkg::*;
#(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
`ifdef VERIRISC_RESUME_EN
  input  logic              resume,
`endif
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              halt,
  output logic [AWIDTH-1:0] pc,
  output logic [DWIDTH-1:0] ac,
  output logic              zero
);
  state_e            state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d, opd;
  logic [DWIDTH-1:0] ir_q, ir_d, ac_q, ac_d, alu_y;
  opcode_e           op;
  logic              resume_i;
`ifdef VERIRISC_RESUME_EN
  assign resume_i = resume;
`else
  assign resume_i = 1'b0;
`endif
  assign op  = opcode_e'(ir_q[DWIDTH-1 -: OPW]);
  assign opd = ir_q[AWIDTH-1:0];
  veririsc_alu #(.DWIDTH(DWIDTH)) u_alu (.op(op), .a(ac_q), .b(mem_rdata), .y(alu_y));
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ac_d    = ac_q;
    case (state_q)
      S_FETCH: if (mem_ready) begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + AWIDTH'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = op == OP_HLT ? S_HALTED :
                  op == OP_STO ? S_OPWR :
                  (op == OP_SKZ || op == OP_JMP) ? S_FETCH : S_OPRD;
        pc_d    = op == OP_JMP ? opd :
                  (op == OP_SKZ && zero) ? pc_q + AWIDTH'(1) : pc_q;
      end
      S_OPRD: if (mem_ready) begin
        ac_d    = alu_y;
        state_d = S_FETCH;
      end
      S_OPWR:   state_d = mem_ready ? S_FETCH : S_OPWR;
      S_HALTED: state_d = resume_i ? S_FETCH : S_HALTED;
      default:  state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      ac_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ac_q    <= ac_d;
    end
  end
  // Requests are gated by rst so an interrupted access never completes.
  assign mem_rd    = rst && (state_q == S_FETCH || state_q == S_OPRD);
  assign mem_wr    = rst && state_q == S_OPWR;
  assign mem_addr  = state_q == S_FETCH ? pc_q : opd;
  assign mem_wdata = ac_q;
  assign halt      = state_q == S_HALTED;
  assign pc        = pc_q;
  assign ac        = ac_q;
  assign zero      = ac_q == '0;
endmodule

// File: tb/tb_veririsc_core.sv
// tb_veririsc_core: scoreboard bench; an ISA-level model predicts every memory access and final state.
module tb_veririsc_core;
  localparam int AW = 5;
  localparam int DW = 8;
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } acc_t;
  logic clk = 0, rst = 0, mem_ready = 0;
  logic mem_rd, mem_wr, halt, zero;
  logic [AW-1:0] mem_addr, pc;
  logic [DW-1:0] mem_wdata, ac, mem_rdata = '0;
`ifdef VERIRISC_RESUME_EN
  logic resume = 0;
`endif
  logic [DW-1:0] mem[2**AW], rmem[2**AW], prog[2**AW];
  int waits[256];
  acc_t exp_q[$];
  int compared = 0, mismatched = 0;
  logic mon_en = 0;
  always #5 clk = ~clk;
  veririsc_core #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk(clk),
    .rst(rst),
`ifdef VERIRISC_RESUME_EN
    .resume(resume),
`endif
    .mem_addr(mem_addr),
    .mem_rd(mem_rd),
    .mem_wr(mem_wr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .halt(halt),
    .pc(pc),
    .ac(ac),
    .zero(zero)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Behavioural memory: drives mem_ready/mem_rdata at negedge with programmed wait states.
  initial begin
    int acc_idx = 0, wcnt = 0;
    logic done = 0, done_wr = 0;
    logic [AW-1:0] done_addr = '0;
    logic [DW-1:0] done_data = '0;
    forever begin
      @(negedge clk);
      if (done && done_wr) mem[done_addr] = done_data;
      if (done) begin
        acc_idx++;
        wcnt = 0;
      end
      done = 0;
      if (!rst) begin
        acc_idx = 0;
        wcnt = 0;
        mem_ready = 1'($urandom_range(1));
        mem_rdata = DW'($urandom);
      end else if (mem_rd || mem_wr) begin
        if (wcnt < waits[acc_idx % 256]) begin
          wcnt++;
          mem_ready = 0;
          mem_rdata = DW'($urandom);
        end else begin
          mem_ready = 1;
          mem_rdata = mem[mem_addr];
          done = 1;
          done_wr = mem_wr;
          done_addr = mem_addr;
          done_data = mem_wdata;
        end
      end else begin
        mem_ready = 1'($urandom_range(1));
        mem_rdata = DW'($urandom);
      end
    end
  end
  // Monitor: pops the expected access whenever one completes.
  initial begin
    acc_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst) chk("rst_quiet", {31'b0, mem_rd | mem_wr}, 0);
      chk("rd_wr_excl", {31'b0, mem_rd & mem_wr}, 0);
      if (mon_en && rst && mem_ready && (mem_rd || mem_wr)) begin
        if (exp_q.size() == 0) chk("unexpected_access", {27'b0, mem_addr}, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("acc_kind", {31'b0, mem_wr}, {31'b0, e.wr});
          chk("acc_addr", {27'b0, mem_addr}, {27'b0, e.addr});
          chk("acc_data", {24'b0, mem_wr ? mem_wdata : mem_rdata}, {24'b0, e.data});
        end
      end
    end
  end
  // ISA interpreter: runs up to kmax instructions, queueing each access and summing cycles.
  task automatic model(input int kmax, output int cyc, output logic h,
                       output logic [AW-1:0] p, output logic [DW-1:0] a);
    int k = 0;
    logic [DW-1:0] ins, d;
    logic [AW-1:0] o;
    logic [2:0] opc;
    p = '0; a = '0; h = 0; cyc = 0;
    for (int n = 0; n < kmax && !h; n++) begin
      ins = rmem[p];
      exp_q.push_back(acc_t'{1'b0, p, ins});
      cyc += 2 + waits[k];
      k++;
      p = p + 1'b1;
      opc = ins[DW-1 -: 3];
      o = ins[AW-1:0];
      if (opc == 0) h = 1;
      else if (opc == 1) begin
        if (a == 0) p = p + 1'b1;
      end else if (opc == 7) p = o;
      else if (opc == 6) begin
        exp_q.push_back(acc_t'{1'b1, o, a});
        rmem[o] = a;
        cyc += 1 + waits[k];
        k++;
      end else begin
        d = rmem[o];
        exp_q.push_back(acc_t'{1'b0, o, d});
        cyc += 1 + waits[k];
        k++;
        a = opc == 2 ? a + d : opc == 3 ? a & d : opc == 4 ? a ^ d : d;
      end
    end
  endtask
  task automatic set_waits(input int mode);
    for (int i = 0; i < 256; i++) waits[i] = mode < 0 ? int'($urandom_range(3)) : mode;
  endtask
  task automatic reset_load();
    @(posedge clk);
    #2 rst = 0;
    mon_en = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    mem = prog;
    rmem = prog;
    exp_q.delete();
    chk("rst_pc", {27'b0, pc}, 0);
    chk("rst_ac", {24'b0, ac}, 0);
    chk("rst_halt", {31'b0, halt}, 0);
  endtask
  task automatic run(input int kmax);
    int cyc, bad;
    logic h;
    logic [AW-1:0] p;
    logic [DW-1:0] a;
    reset_load();
    model(kmax, cyc, h, p, a);
    mon_en = 1;
    @(posedge clk);
    #2 rst = 1;
    repeat (cyc - 1) @(posedge clk);
    #6 chk("halt_early", {31'b0, halt}, 0);
    @(posedge clk);
    #2 if (!h) mon_en = 0;
    #4;
    chk("pc", {27'b0, pc}, {27'b0, p});
    chk("ac", {24'b0, ac}, {24'b0, a});
    chk("halt", {31'b0, halt}, {31'b0, h});
    chk("zero", {31'b0, zero}, {31'b0, a == 0});
    chk("queue_drained", exp_q.size(), 0);
    bad = 0;
    for (int i = 0; i < 2**AW; i++) if (mem[i] !== rmem[i]) bad++;
    chk("mem_image", bad, 0);
    if (h) begin
      repeat (4) @(posedge clk);
      #6;
      chk("frozen_pc", {27'b0, pc}, {27'b0, p});
      chk("frozen_ac", {24'b0, ac}, {24'b0, a});
      chk("frozen_halt", {31'b0, halt}, 1);
    end
    exp_q.delete();
  endtask
  task automatic clear_prog();
    for (int i = 0; i < 2**AW; i++) prog[i] = '0;
  endtask
  initial begin
    // LDA 10, ADD 11, STO 12, HLT with zero and then three wait states per access
    for (int w = 0; w < 4; w += 3) begin
      clear_prog();
      prog[0] = 8'hAA; prog[1] = 8'h4B; prog[2] = 8'hCC; prog[3] = 8'h00;
      prog[10] = 8'h7F; prog[11] = 8'h01;
      set_waits(w);
      run(100);
      chk("prog_mem12", {24'b0, mem[12]}, 32'h80);
      chk("prog_pc", {27'b0, pc}, 4);
    end
`ifdef VERIRISC_RESUME_EN
    mon_en = 0;
    @(posedge clk);
    #2 resume = 1;
    @(posedge clk);
    #2 resume = 0;
    #4;
    chk("resume_halt", {31'b0, halt}, 0);
    chk("resume_rd", {31'b0, mem_rd}, 1);
    chk("resume_addr", {27'b0, mem_addr}, 4);
`endif
    // ADD overflow: FF + 02
    clear_prog();
    prog[0] = 8'hAA; prog[1] = 8'h4B; prog[10] = 8'hFF; prog[11] = 8'h02;
    set_waits(0);
    run(100);
    chk("ovf_ac", {24'b0, ac}, 1);
    chk("ovf_zero", {31'b0, zero}, 0);
    // SKZ at pc 5 with ac=0 skips to 7
    clear_prog();
    prog[0] = 8'hE5; prog[5] = 8'h20;
    run(100);
    chk("skz0_pc", {27'b0, pc}, 8);
    // SKZ with ac=1 falls through to 6
    clear_prog();
    prog[0] = 8'hB4; prog[1] = 8'hE5; prog[5] = 8'h20; prog[20] = 8'h01;
    run(100);
    chk("skz1_pc", {27'b0, pc}, 7);
    // JMP 31 then SKZ at 31 wraps pc to 1
    clear_prog();
    prog[0] = 8'hFF; prog[31] = 8'h20;
    run(100);
    chk("wrap_pc", {27'b0, pc}, 2);
    // Reset asserted during an OPWR wait: no write, state cleared
    clear_prog();
    prog[0] = 8'hAA; prog[1] = 8'hCC; prog[10] = 8'h7F; prog[12] = 8'h55;
    set_waits(0);
    waits[3] = 3;
    reset_load();
    @(posedge clk);
    #2 rst = 1;
    repeat (5) @(posedge clk);
    #6;
    chk("opwr_wr", {31'b0, mem_wr}, 1);
    chk("opwr_ac", {24'b0, ac}, 32'h7F);
    @(posedge clk);
    #2 rst = 0;
    #4 chk("midrst_wr", {31'b0, mem_wr}, 0);
    @(posedge clk);
    #6;
    chk("midrst_pc", {27'b0, pc}, 0);
    chk("midrst_ac", {24'b0, ac}, 0);
    chk("midrst_halt", {31'b0, halt}, 0);
    chk("midrst_mem12", {24'b0, mem[12]}, 32'h55);
    // Random programs, HLT made rarer so runs are longer
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 2**AW; i++) begin
        prog[i] = DW'($urandom);
        if (prog[i][7:5] == 3'd0 && $urandom_range(3) != 0) prog[i][7:5] = 3'($urandom_range(7, 1));
      end
      set_waits(r % 3 == 0 ? 0 : -1);
      run(30);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
